// File: rtl/can_pkg.sv
// Shared CAN transmit definitions: FSM states and bus level constants.
package can_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      STUFF
   } can_state_e;

   localparam logic CAN_RECESSIVE = 1'b1;
   localparam logic CAN_DOMINANT  = 1'b0;

   // Default identical-bit run length that forces a stuff bit.
   localparam int unsigned CAN_STUFF_LEN = 5;

endpackage

// File: rtl/can_bit_timer.sv
// CAN bit-slot prescaler: counts clk cycles within one bit slot and strobes
// the sample point and the last cycle of the slot.
module can_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 100,
   parameter int unsigned SAMPLE_POINT = 70
) (
   input  logic clk,
   input  logic rst,
   input  logic i_run,      // a bit slot is in progress
   input  logic i_start,    // restart at 0 for a new slot
   input  logic i_clear,    // return to 0 when going idle
   output logic o_bit_end,
   output logic o_sample
);

   localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] LAST_IDX = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] SAMPLE_IDX = TW'(SAMPLE_POINT);

   logic [TW-1:0] r_timer;

   // Slot counter; holds at the last index until a launch or idle restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timer <= '0;
      end else if (i_start || i_clear) begin
         r_timer <= '0;
      end else if (i_run && (r_timer != LAST_IDX)) begin
         r_timer <= r_timer + 1'b1;
      end
   end

   assign o_bit_end = i_run && (r_timer == LAST_IDX);
   assign o_sample  = i_run && (r_timer == SAMPLE_IDX);

endmodule

// File: rtl/can_stuff_tx.sv
// CAN bit-level transmit stage: bit timing, exact per-bit stuffing and
// read-back monitoring for bit errors and arbitration loss.
module can_stuff_tx
   import can_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 100,
   parameter int unsigned SAMPLE_POINT = 70,
   parameter int unsigned RUN_LEN      = CAN_STUFF_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic in_bit,
   input  logic in_stuff_en,
   input  logic in_arb,
   output logic in_ready,
   input  logic rx,
   output logic tx,
   output logic busy,
   output logic stuff_pulse,
   output logic bit_err,
   output logic arb_lost
);

   localparam int unsigned RW = $clog2(RUN_LEN + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);
   localparam logic [RW-1:0] RUN_ONE = RW'(1);

   can_state_e    r_state, w_state_nxt;
   logic          r_tx, w_tx_nxt;
   logic [RW-1:0] r_run, w_run_nxt;
   logic          r_last, w_last_nxt;
   logic          r_cur_stuff_en, w_cur_stuff_en_nxt;
   logic          r_cur_arb, w_cur_arb_nxt;
   logic          r_stuff_pulse, w_stuff_pulse_nxt;
   logic          r_bit_err, w_bit_err_nxt;
   logic          r_arb_lost, w_arb_lost_nxt;

   logic w_bit_end, w_sample, w_start, w_clear;
   logic w_stuff_due, w_in_ready, w_xfer, w_busy;

   assign w_busy      = (r_state != IDLE);
   assign w_stuff_due = r_cur_stuff_en && (r_run == RUN_MAX);
   assign w_in_ready  = (r_state == IDLE) || (w_bit_end && !w_stuff_due);
   assign w_xfer      = in_valid && w_in_ready;

   can_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .SAMPLE_POINT (SAMPLE_POINT)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_run     (w_busy),
      .i_start   (w_start),
      .i_clear   (w_clear),
      .o_bit_end (w_bit_end),
      .o_sample  (w_sample)
   );

   // Next-state: read-back check, stuff insertion, idle fallback, then launch.
   always_comb begin
      w_state_nxt        = r_state;
      w_tx_nxt           = r_tx;
      w_run_nxt          = r_run;
      w_last_nxt         = r_last;
      w_cur_stuff_en_nxt = r_cur_stuff_en;
      w_cur_arb_nxt      = r_cur_arb;
      w_stuff_pulse_nxt  = 1'b0;
      w_bit_err_nxt      = 1'b0;
      w_arb_lost_nxt     = 1'b0;
      w_start            = 1'b0;
      w_clear            = 1'b0;

      unique case (r_state)
         IDLE: begin
         end
         DATA, STUFF: begin
            if (w_sample && (rx != r_tx)) begin
               // Losing arbitration means someone drove dominant over our recessive.
               if ((r_tx == CAN_RECESSIVE) && r_cur_arb) begin
                  w_arb_lost_nxt = 1'b1;
                  w_state_nxt    = IDLE;
                  w_tx_nxt       = CAN_RECESSIVE;
                  w_run_nxt      = '0;
                  w_last_nxt     = CAN_RECESSIVE;
                  w_clear        = 1'b1;
               end else begin
                  w_bit_err_nxt = 1'b1;
               end
            end else if (w_bit_end) begin
               if ((r_state == DATA) && w_stuff_due) begin
                  // Stuff bit counts as the first bit of the opposite-level run.
                  w_state_nxt       = STUFF;
                  w_tx_nxt          = ~r_last;
                  w_last_nxt        = ~r_last;
                  w_run_nxt         = RUN_ONE;
                  w_stuff_pulse_nxt = 1'b1;
                  w_start           = 1'b1;
               end else begin
                  // Underflow: overridden below if a bit is handed over now.
                  w_state_nxt = IDLE;
                  w_tx_nxt    = CAN_RECESSIVE;
                  w_run_nxt   = '0;
                  w_last_nxt  = CAN_RECESSIVE;
                  w_clear     = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      if (w_xfer) begin
         w_state_nxt        = DATA;
         w_tx_nxt           = in_bit;
         w_cur_stuff_en_nxt = in_stuff_en;
         w_cur_arb_nxt      = in_arb;
         w_last_nxt         = in_bit;
         w_start            = 1'b1;
         w_clear            = 1'b0;
         if (!in_stuff_en) begin
            w_run_nxt = '0;
         end else if (in_bit == r_last) begin
            w_run_nxt = (r_run == RUN_MAX) ? RUN_MAX : r_run + 1'b1;
         end else begin
            w_run_nxt = RUN_ONE;
         end
      end
   end

   // State and output registers; reset forces the bus recessive at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_tx           <= CAN_RECESSIVE;
         r_run          <= '0;
         r_last         <= CAN_RECESSIVE;
         r_cur_stuff_en <= 1'b0;
         r_cur_arb      <= 1'b0;
         r_stuff_pulse  <= 1'b0;
         r_bit_err      <= 1'b0;
         r_arb_lost     <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_tx           <= w_tx_nxt;
         r_run          <= w_run_nxt;
         r_last         <= w_last_nxt;
         r_cur_stuff_en <= w_cur_stuff_en_nxt;
         r_cur_arb      <= w_cur_arb_nxt;
         r_stuff_pulse  <= w_stuff_pulse_nxt;
         r_bit_err      <= w_bit_err_nxt;
         r_arb_lost     <= w_arb_lost_nxt;
      end
   end

   assign in_ready    = w_in_ready;
   assign tx          = r_tx;
   assign busy        = w_busy;
   assign stuff_pulse = r_stuff_pulse;
   assign bit_err     = r_bit_err;
   assign arb_lost    = r_arb_lost;

endmodule

// File: tb/tb_can_stuff_tx.sv
// Self-checking bench for can_stuff_tx with 4 clocks per bit.
module tb_can_stuff_tx;

   localparam int unsigned CPB = 4;
   localparam int unsigned SP  = 2;
   localparam int unsigned RL  = 5;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_bit, in_stuff_en, in_arb, in_ready;
   logic rx, tx, busy, stuff_pulse, bit_err, arb_lost;
   logic force_rx, force_val;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int          n;
      logic [15:0] bits;
      logic        se;
      logic        arb;
      int          stuffs;
      int          cycles;
   } vec_t;

   typedef struct packed {
      logic tx;
      logic sp;
      logic rdy;
   } exp_t;

   vec_t vecs[7];
   exp_t exp_q[$];

   always #5 clk = ~clk;

   assign rx = force_rx ? force_val : tx;

   can_stuff_tx #(
      .CLKS_PER_BIT (CPB),
      .SAMPLE_POINT (SP),
      .RUN_LEN      (RL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .in_stuff_en (in_stuff_en),
      .in_arb      (in_arb),
      .in_ready    (in_ready),
      .rx          (rx),
      .tx          (tx),
      .busy        (busy),
      .stuff_pulse (stuff_pulse),
      .bit_err     (bit_err),
      .arb_lost    (arb_lost)
   );

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Reference stuffing model: expected tx, stuff_pulse and in_ready per cycle.
   task automatic build(input vec_t v);
      int   run = 0;
      logic last = 1'b1;
      logic b;
      logic slots[$];
      logic is_st[$];
      for (int i = 0; i < v.n; i++) begin
         b = v.bits[i];
         if (!v.se) run = 0;
         else if (b == last) run++;
         else run = 1;
         last = b;
         slots.push_back(b);
         is_st.push_back(1'b0);
         if (v.se && run == RL) begin
            slots.push_back(!last);
            is_st.push_back(1'b1);
            run  = 1;
            last = !last;
         end
      end
      for (int s = 0; s < slots.size(); s++) begin
         for (int k = 0; k < CPB; k++) begin
            exp_q.push_back('{tx: slots[s], sp: is_st[s] && k == 0,
                              rdy: (k == CPB - 1) && !(s + 1 < slots.size() && is_st[s + 1])});
         end
      end
   endtask

   // Drives one vector with in_valid held and compares every busy cycle.
   task automatic run_vec(input int id, input vec_t v);
      int   idx = 0;
      int   cyc = 0;
      int   stuffs = 0;
      int   busy_cyc = 0;
      bit   seen = 0;
      bit   hs;
      exp_t e;
      build(v);
      @(posedge clk);
      #1;
      in_stuff_en = v.se;
      in_arb      = v.arb;
      in_bit      = v.bits[0];
      in_valid    = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (busy) begin
            seen = 1;
            busy_cyc++;
            if (stuff_pulse) stuffs++;
            if (exp_q.size() == 0) begin
               check($sformatf("v%0d extra busy cycle %0d", id, cyc), int'(busy), 0);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("v%0d c%0d tx", id, cyc), int'(tx), int'(e.tx));
               check($sformatf("v%0d c%0d stuff_pulse", id, cyc), int'(stuff_pulse), int'(e.sp));
               check($sformatf("v%0d c%0d in_ready", id, cyc), int'(in_ready), int'(e.rdy));
               check($sformatf("v%0d c%0d err/arb", id, cyc), int'({bit_err, arb_lost}), 0);
            end
         end
         if (idx == v.n && !busy && seen) break;
         if (cyc > 400) begin
            check($sformatf("v%0d timeout busy", id), int'(busy), 0);
            check($sformatf("v%0d timeout bits sent", id), idx, v.n);
            break;
         end
         hs = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (hs) begin
            idx++;
            if (idx < v.n) in_bit = v.bits[idx];
            else in_valid = 1'b0;
         end
      end
      check($sformatf("v%0d leftover expected cycles", id), exp_q.size(), 0);
      exp_q.delete();
      check($sformatf("v%0d stuff count", id), stuffs, v.stuffs);
      check($sformatf("v%0d busy cycles", id), busy_cyc, v.cycles);
      repeat (2) @(negedge clk);
   endtask

   // One bit with rx forced to a fixed level; checks the pulse after the sample point.
   task automatic arb_case(input int id, input logic b, input logic a, input logic rxv,
                           input logic exp_arb, input logic exp_err);
      @(posedge clk);
      #1;
      force_rx    = 1'b1;
      force_val   = rxv;
      in_bit      = b;
      in_arb      = a;
      in_stuff_en = 1'b1;
      in_valid    = 1'b1;
      @(negedge clk);
      check($sformatf("a%0d idle in_ready", id), int'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check($sformatf("a%0d sample busy", id), int'(busy), 1);
      check($sformatf("a%0d sample pulses", id), int'({bit_err, arb_lost}), 0);
      @(negedge clk);
      check($sformatf("a%0d arb_lost", id), int'(arb_lost), int'(exp_arb));
      check($sformatf("a%0d bit_err", id), int'(bit_err), int'(exp_err));
      check($sformatf("a%0d busy after sample", id), int'(busy), int'(!exp_arb));
      check($sformatf("a%0d tx after sample", id), int'(tx), exp_arb ? 1 : int'(b));
      if (exp_arb) check($sformatf("a%0d in_ready after loss", id), int'(in_ready), 1);
      @(negedge clk);
      check($sformatf("a%0d pulses cleared", id), int'({bit_err, arb_lost}), 0);
      check($sformatf("a%0d idle busy", id), int'(busy), 0);
      check($sformatf("a%0d idle tx", id), int'(tx), 1);
      force_rx = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_bit      = 1'b1;
      in_stuff_en = 1'b0;
      in_arb      = 1'b0;
      force_rx    = 1'b0;
      force_val   = 1'b1;

      //           n   bits      se    arb   stuffs cycles
      vecs[0] = '{6,  16'h0020, 1'b1, 1'b0, 1, 28};  // 0x5 then 1
      vecs[1] = '{9,  16'h01E0, 1'b1, 1'b0, 2, 44};  // stuff 1 joins the ones run
      vecs[2] = '{7,  16'h0000, 1'b0, 1'b0, 0, 28};  // stuffing disabled
      vecs[3] = '{3,  16'h0000, 1'b1, 1'b0, 0, 12};  // underflow after 3 bits
      vecs[4] = '{6,  16'h0000, 1'b1, 1'b0, 1, 28};  // fresh run after idle
      vecs[5] = '{10, 16'h0155, 1'b1, 1'b0, 0, 40};  // alternating, no stuff
      vecs[6] = '{11, 16'h07FF, 1'b1, 1'b1, 2, 52};  // recessive runs, arb field

      #1;
      check("reset tx", int'(tx), 1);
      check("reset busy", int'(busy), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post-reset in_ready", int'(in_ready), 1);
      check("post-reset pulses", int'({stuff_pulse, bit_err, arb_lost}), 0);

      // Reset in the middle of a dominant bit.
      in_valid    = 1'b1;
      in_bit      = 1'b0;
      in_stuff_en = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("mid-bit tx dominant", int'(tx), 0);
      check("mid-bit busy", int'(busy), 1);
      #2;
      rst = 1'b1;
      #1;
      check("async reset tx", int'(tx), 1);
      check("async reset busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("after reset busy", int'(busy), 0);
      check("after reset tx", int'(tx), 1);
      check("after reset in_ready", int'(in_ready), 1);
      check("after reset pulses", int'({stuff_pulse, bit_err, arb_lost}), 0);

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      arb_case(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      arb_case(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      arb_case(2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

      // The stage must still transmit normally after an arbitration loss.
      run_vec(7, vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/can_stuff_tx.md
Name: can_stuff_tx

Overview:
- Parametrised CAN bit-level transmit stage. It sits between the frame serialiser, which supplies one NRZ bit per handshake, and the tx pin.
- Generates bit timing from clk with an internal prescaler.
- Inserts a complementary stuff bit after RUN_LEN identical bits while stuffing is enabled.
- Monitors rx at a configurable sample point to detect bit errors and arbitration loss. This replaces the time-window stuffing hack with exact per-bit stuffing.

Parameters:
- CLKS_PER_BIT, 100, clk cycles per CAN bit; legal range >= 4.
- SAMPLE_POINT, 70, timer index at which rx is sampled; legal range 1..CLKS_PER_BIT-2.
- RUN_LEN, 5, identical-bit run length that forces a stuff bit; legal range >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- in_valid  in  1  upstream presents a bit.
- in_bit  in  1  bit value; 1 = recessive.
- in_stuff_en  in  1  this bit participates in stuffing (SOF..CRC).
- in_arb  in  1  this bit is in the arbitration field.
- in_ready  out  1  stage accepts a bit this cycle.
- rx  in  1  bus read-back.
- tx  out  1  bus drive; 1 = recessive.
- busy  out  1  bit slot in progress.
- stuff_pulse  out  1  one-cycle pulse when a stuff bit is launched.
- bit_err  out  1  one-cycle pulse on read-back mismatch.
- arb_lost  out  1  one-cycle pulse on arbitration loss.

Behaviour:
- Reset is asynchronous, active-high, on rst; clock is clk.
- Reset values: tx=1, busy=0, stuff_pulse=0, bit_err=0, arb_lost=0, state=IDLE, timer=0, run=0, last=1. in_ready=1 once out of reset (IDLE).
- States: IDLE, DATA, STUFF.
- Timer runs 0..CLKS_PER_BIT-1 in DATA/STUFF. bit_end = (timer == CLKS_PER_BIT-1). sample = (timer == SAMPLE_POINT).
- in_ready is combinational: (state==IDLE) OR (bit_end AND NOT stuff_due).
- stuff_due = cur_stuff_en AND run == RUN_LEN.
- Transfer occurs on in_valid AND in_ready. The bit appears on tx the next clk (latency 1), timer=0, state=DATA. in_bit, in_stuff_en and in_arb are latched as cur_*.
- Run update at data launch:
  - stuff_en=0 -> run=0.
  - else if in_bit==last -> run=run+1.
  - else run=1.
  - last=in_bit in all cases.
- At bit_end with stuff_due: state=STUFF, tx=~last, stuff_pulse=1 for 1 clk, run=1, last=~last. cur_arb is kept from the preceding data bit. in_ready stays low.
- At bit_end of STUFF: in_ready=1. A transfer launches DATA; otherwise go IDLE.
- At bit_end of DATA without stuff_due and no in_valid: IDLE, tx=1, run=0, last=1.
- A stuff bit is never due while cur_stuff_en=0. Stuffing disabled mid-frame means no stuff even if run==RUN_LEN.
- Sample point: if rx != tx while in DATA or STUFF:
  - If tx==1 AND cur_arb: arb_lost=1 for 1 clk, go IDLE next clk, tx=1, run=0. No in_ready until the next clk (IDLE).
  - Otherwise bit_err=1 for 1 clk and transmission continues unchanged.
- Arbitration loss overrides a stuff_due in the same bit. bit_end cannot coincide with sample, given the parameter range.
- busy = (state != IDLE).
- Widths:
  - timer is $clog2(CLKS_PER_BIT) bits and wraps to 0 only via launch.
  - run is $clog2(RUN_LEN+1) bits and saturates at RUN_LEN. It never exceeds RUN_LEN because a stuff bit resets it to 1.
- rst mid-bit: immediate recessive tx, everything returns to its reset values, and the partial bit is discarded.
- No synchroniser inside: rx is expected to be pre-synchronised at top level.

Decomposition:
- Shared package can_pkg:
  - state enum {IDLE, DATA, STUFF}
  - CAN_RECESSIVE=1'b1, CAN_DOMINANT=1'b0
  - CAN_STUFF_LEN=5 (default for RUN_LEN).
- One sub-module, can_bit_timer: prescaler counter with start input and bit_end/sample strobes, parametrised by CLKS_PER_BIT and SAMPLE_POINT.

Test Plan (CLKS_PER_BIT=4, SAMPLE_POINT=2, RUN_LEN=5, rx looped to tx unless stated):
1. Reset/idle: assert rst mid-bit with tx=0 -> tx=1 immediately, busy=0, in_ready=1 after release, no pulses.
2. Five dominant bits with stuff_en=1, then a 1 -> tx shows 0 x5, then stuff 1 (stuff_pulse at cycle 20), then data 1. in_ready is low during bit_end of the 5th bit and high at the end of the stuff slot. Total 28 cycles.
3. Run crossing a stuff: 0x5 then 1x4 with stuff_en=1 -> stuff 1 after the zeros counts toward the ones run. A second stuff 0 is inserted after 4 data 1s. stuff_pulse is seen twice.
4. Stuff disabled: 0x7 with stuff_en=0 -> no stuff bit, stuff_pulse never asserted, 28 cycles of tx=0.
5. Arbitration loss: send 1 with in_arb=1, force rx=0 -> arb_lost pulse at timer=2, state IDLE next clk, tx=1, busy=0. The same with in_arb=0 -> bit_err pulse only and transmission continues.
6. Underflow: drop in_valid after 3 bits -> IDLE at bit_end, tx=1, run reset. The next 0 starts a new run (stuff only after 5 more).
